fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame-level sequencer for the radix-2 FFT datapath. It accepts a real sample stream with a valid/ready handshake and loads exactly N = 2**N_2 samples into the datapath. It then holds the compute enable until the datapath reports done, and drains the N complex bins through a valid/ready output port. A watchdog flags a datapath that never completes.

## Interface
Parameters:
- width, 16, real/imag component bit width
- N_2, 5, log2 of FFT points N
- TIMEOUT, 1024, max COMPUTE cycles before error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  level; frames are processed while high
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts a sample this cycle
- s_data  in  width  real input sample
- fft_load  out  1  datapath load strobe, one per accepted sample
- fft_rd  out  width  sample to datapath
- fft_start  out  1  datapath compute enable (level)
- fft_done  in  1  datapath finished
- out_adr  out  N_2  bin address to datapath readout
- fft_wd  in  2*width  bin data at out_adr, same cycle (asynchronous RAM read)
- m_valid  out  1  output bin valid
- m_ready  in  1  downstream accepts bin
- m_data  out  2*width  {re, im} bin
- m_idx  out  N_2  bin index of m_data
- m_last  out  1  m_data is bin N-1
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog error
- frames  out  16  completed-frame count, wraps at 2**16

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE → LOAD when run=1 and err=0. IDLE → IDLE otherwise.
- LOAD:
  - s_ready=1; fft_rd=s_data (combinational).
  - fft_load = s_valid & s_ready; each accept increments cnt.
  - The accept with cnt=N-1 moves to COMPUTE, and cnt clears to 0.
  - Gaps in s_valid stall the load with no effect on state.
- COMPUTE:
  - fft_start=1 every cycle in this state; wdog increments each cycle.
  - fft_done=1 → DRAIN, wdog clears.
  - If wdog reaches TIMEOUT-1 without fft_done: err←1, go to IDLE, fft_start drops.
- DRAIN:
  - m_valid=1; out_adr=m_idx=cnt; m_data=fft_wd; m_last=(cnt==N-1).
  - On m_valid & m_ready: cnt increments.
  - On the last handshake: frames increments, then go to LOAD if run=1, else IDLE.
  - m_data is stable while m_valid=1 and m_ready=0 (cnt is held).
- Dropping run mid-frame has no effect; the frame completes, then the block goes to IDLE.
- err clears only on reset. While err=1 the block stays in IDLE.
- fft_done outside COMPUTE is ignored.
- cnt is N_2+1 bits internally so it does not alias at N-1; cnt==N-1 is the terminal compare.

## Timing
- Reset values: state=IDLE, cnt=0, wdog=0, err=0, frames=0. All outputs are 0, except fft_rd/m_data, which follow their combinational sources.
- s_ready is registered-state decoded: it rises the cycle after IDLE→LOAD.
- Minimum load is N cycles. The first fft_start is the cycle after the N-th accept.
- DRAIN begins the cycle after fft_done is sampled high.
- Continuous run with m_ready=1: N bins in N cycles, then LOAD on the following cycle.
- Reset in any state returns to IDLE on the next edge and aborts the frame. Datapath recovery is outside this block.
- Simultaneous fft_done and watchdog expiry: fft_done wins, and no error is raised.

## Structure
- Package fft_pkg holds:
  - typedef enum fft_state_t {IDLE, LOAD, COMPUTE, DRAIN}
  - localparam helper for N = 2**N_2
- One sub-module, fft_watchdog: counter with clear/enable and an expire output, parameterised on TIMEOUT.
- The rest is a single FSM with the cnt and frames registers.

## Test plan
Defaults N_2=5 (N=32) unless stated.
- Reset then run=1 with s_valid=1 constantly, fft_done pulsed 40 cycles after fft_start rises, m_ready=1 → exactly 32 fft_load pulses; fft_start high for 41 cycles; 32 bins with m_idx 0..31; m_last only on idx 31; frames=1.
- s_valid toggling 1,0,1,0 → 32 accepts over 63 cycles; fft_load never asserted while s_valid=0.
- In DRAIN, m_ready held low 5 cycles at idx 7 → m_idx=7 and m_data stable for 5 cycles; no idx skipped.
- TIMEOUT=16 and fft_done never asserted → err=1 after 16 COMPUTE cycles; state IDLE; s_ready stays 0 with run=1 until reset.
- reset asserted at accept 10 of LOAD → next cycle busy=0, s_ready=0, frames unchanged; the next frame loads 32 fresh samples.
- Three back-to-back frames with run=1 → frames=3; LOAD entered the cycle after each m_last handshake; fft_done pulse during LOAD ignored.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the FFT frame sequencer: controller state encoding and
// the point-count helper used to size the sample/bin counter.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } fft_state_t;

  localparam int DEF_N_2 = 5;

  function automatic int fft_points(input int n_2);
    return 1 << n_2;
  endfunction

endpackage

// File: rtl/fft_watchdog.sv
// Compute-phase watchdog: counts enabled cycles and flags expiry once the
// count reaches TIMEOUT-1. It saturates there until cleared.
module fft_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wdog <= '0;
    end else if (i_en && !o_expire) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign o_expire = (r_wdog == LAST);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the radix-2 FFT datapath: loads N samples, holds the
// compute enable until done (or watchdog expiry), then drains N bins.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int width   = 16,
  parameter int N_2     = DEF_N_2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [width-1:0]   s_data,
  output logic               fft_load,
  output logic [width-1:0]   fft_rd,
  output logic               fft_start,
  input  logic               fft_done,
  output logic [N_2-1:0]     out_adr,
  input  logic [2*width-1:0] fft_wd,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*width-1:0] m_data,
  output logic [N_2-1:0]     m_idx,
  output logic               m_last,
  output logic               busy,
  output logic               err,
  output logic [15:0]        frames,
  output fft_state_t         dbg_state
);

  localparam int N = fft_points(N_2);
  // One extra bit so the terminal value N-1 never aliases with a wrapped 0.
  localparam logic [N_2:0] CNT_LAST = (N_2 + 1)'(N - 1);

  fft_state_t     r_state;
  logic [N_2:0]   r_cnt;
  logic [15:0]    r_frames;
  logic           r_err;

  logic w_accept;
  logic w_bin_hs;
  logic w_cnt_last;
  logic w_expire;
  logic w_wdog_clr;
  logic w_wdog_en;

  // Both ports use plain valid/ready: a transfer happens in any cycle where
  // valid and ready are both high; ready here is decoded from registered state.
  assign w_accept   = s_valid && (r_state == LOAD);
  assign w_bin_hs   = m_ready && (r_state == DRAIN);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_wdog_en  = (r_state == COMPUTE);
  assign w_wdog_clr = (r_state != COMPUTE) || fft_done;

  fft_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wdog_clr),
    .i_en     (w_wdog_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_frames <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run && !r_err) r_state <= LOAD;
        end
        LOAD: begin
          if (w_accept) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= COMPUTE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          // A done on the expiry cycle still counts as a successful compute.
          if (fft_done) begin
            r_state <= DRAIN;
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_bin_hs) begin
            if (w_cnt_last) begin
              r_cnt    <= '0;
              r_frames <= r_frames + 16'd1;
              r_state  <= run ? LOAD : IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = (r_state == LOAD);
  assign fft_load  = w_accept;
  assign fft_rd    = s_data;
  assign fft_start = (r_state == COMPUTE);
  assign out_adr   = r_cnt[N_2-1:0];
  assign m_valid   = (r_state == DRAIN);
  assign m_data    = fft_wd;
  assign m_idx     = r_cnt[N_2-1:0];
  assign m_last    = (r_state == DRAIN) && w_cnt_last;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;
  assign frames    = r_frames;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: main instance with the default watchdog
// and a second instance with TIMEOUT=16 for the expiry case.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int W    = 16;
  localparam int N2   = 5;
  localparam int NP   = 32;
  localparam int SB_W = 1 + N2 + 2 * W;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic           run      = 1'b0;
  logic           s_valid  = 1'b0;
  logic [W-1:0]   s_data   = '0;
  logic           m_ready  = 1'b1;
  logic           dp_done  = 1'b0;
  logic           tb_done  = 1'b0;
  logic           fft_done;
  logic [2*W-1:0] fft_wd;
  logic           s_ready, fft_load, fft_start, m_valid, m_last, busy, err;
  logic [W-1:0]   fft_rd;
  logic [N2-1:0]  out_adr, m_idx;
  logic [2*W-1:0] m_data;
  logic [15:0]    frames;
  fft_state_t     dbg_state;

  // watchdog instance
  logic           run2     = 1'b0;
  logic           s_valid2 = 1'b0;
  logic [W-1:0]   s_data2  = '0;
  logic           fft_done2 = 1'b0;
  logic [2*W-1:0] fft_wd2  = '0;
  logic           m_ready2 = 1'b1;
  logic           s_ready2, fft_load2, fft_start2, m_valid2, m_last2, busy2, err2;
  logic [W-1:0]   fft_rd2;
  logic [N2-1:0]  out_adr2, m_idx2;
  logic [2*W-1:0] m_data2;
  logic [15:0]    frames2;
  fft_state_t     dbg_state2;

  fft_frame_ctrl #(.width(W), .N_2(N2), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .run(run), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .fft_load(fft_load), .fft_rd(fft_rd), .fft_start(fft_start),
    .fft_done(fft_done), .out_adr(out_adr), .fft_wd(fft_wd), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .err(err), .frames(frames), .dbg_state(dbg_state)
  );

  fft_frame_ctrl #(.width(W), .N_2(N2), .TIMEOUT(16)) dut_wd (
    .clk(clk), .reset(reset), .run(run2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .fft_load(fft_load2), .fft_rd(fft_rd2), .fft_start(fft_start2),
    .fft_done(fft_done2), .out_adr(out_adr2), .fft_wd(fft_wd2), .m_valid(m_valid2),
    .m_ready(m_ready2), .m_data(m_data2), .m_idx(m_idx2), .m_last(m_last2),
    .busy(busy2), .err(err2), .frames(frames2), .dbg_state(dbg_state2)
  );

  function automatic logic [2*W-1:0] bin_val(input logic [N2-1:0] i);
    logic [W-1:0] re, im;
    re = 16'h0100 + 16'(i) * 16'd37;
    im = 16'hF000 - 16'(i);
    return {re, im};
  endfunction

  // datapath model: bin RAM read, and done 40 cycles after start rises
  always_comb fft_wd = bin_val(out_adr);
  assign fft_done = dp_done | tb_done;

  int st_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (fft_start) st_cyc++;
    else st_cyc = 0;
    dp_done = (st_cyc == 41);
  end

  // scoreboard
  logic [SB_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NP; i++) exp_q.push_back({(i == NP - 1), 5'(i), bin_val(5'(i))});
  endtask

  // monitor
  int cyc = 0;
  int load_cnt = 0, start_cnt = 0, wd_start_cnt = 0;
  int first_load_cyc = -1, last_load_cyc = -1, first_start_cyc = -1;
  int last_hs_cyc = -1;
  bit b2b_mode = 1'b0;
  logic prev_sready = 1'b0;

  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    cyc++;
    if (fft_load) begin
      load_cnt++;
      last_load_cyc = cyc;
      if (first_load_cyc < 0) first_load_cyc = cyc;
    end
    if (fft_start) begin
      start_cnt++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
    end
    if (!s_valid) check("load_wo_valid", fft_load, 0);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("bin_q_empty", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("bin", {m_last, m_idx, m_data}, e);
      end
      if (m_last) last_hs_cyc = cyc;
    end
    if (s_ready && !prev_sready && b2b_mode && last_hs_cyc >= 0)
      check("load_after_last", 64'(cyc - last_hs_cyc), 1);
    prev_sready = s_ready;
    if (fft_start2) wd_start_cnt++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counters();
    load_cnt = 0; start_cnt = 0;
    first_load_cyc = -1; last_load_cyc = -1; first_start_cyc = -1;
  endtask

  task automatic wait_frames(input string tag, input int target);
    int n;
    n = 0;
    while (frames != 16'(target) && n < 2000) begin
      step();
      n++;
    end
    check(tag, frames, target);
  endtask

  task automatic start_one_frame();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int f0, n;
    bit seen;

    // reset values
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("rst_busy", busy, 0);
    check("rst_sready", s_ready, 0);
    check("rst_start", fft_start, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mlast", m_last, 0);
    check("rst_err", err, 0);
    check("rst_frames", frames, 0);
    check("rst_adr", out_adr, 0);
    check("rst_state", dbg_state, IDLE);
    s_data = 16'($urandom_range(0, 65535));
    #1;
    check("fft_rd_follow", fft_rd, s_data);
    check("m_data_follow", m_data, bin_val(5'd0));

    // reset during LOAD at the 10th accept
    s_valid = 1'b1;
    run = 1'b1;
    step();
    repeat (9) step();
    reset = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_sready", s_ready, 0);
    check("abort_load", fft_load, 0);
    check("abort_frames", frames, 0);
    reset = 1'b0;
    run = 1'b0;
    step();

    // full frame, run dropped during LOAD
    clr_counters();
    push_frame();
    start_one_frame();
    wait_frames("main_frames", 1);
    check("main_loads", load_cnt, NP);
    check("main_start_cycles", start_cnt, 41);
    check("main_start_lat", 64'(first_start_cyc - last_load_cyc), 1);
    step();
    check("main_idle", busy, 0);

    // s_valid toggling 1,0,1,0
    clr_counters();
    push_frame();
    s_valid = 1'b0;
    run = 1'b1;
    step();
    run = 1'b0;
    s_valid = 1'b1;
    repeat (70) begin
      step();
      s_valid = ~s_valid;
    end
    s_valid = 1'b0;
    wait_frames("tog_frames", 2);
    check("tog_loads", load_cnt, NP);
    check("tog_span", 64'(last_load_cyc - first_load_cyc + 1), 63);

    // downstream stall at bin 7
    clr_counters();
    push_frame();
    s_valid = 1'b1;
    start_one_frame();
    n = 0;
    while (!(m_valid && m_idx == 5'd7) && n < 500) begin
      step();
      n++;
    end
    check("stall_reach", m_idx, 7);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", m_valid, 1);
      check("stall_idx", m_idx, 7);
      check("stall_data", m_data, bin_val(5'd7));
      step();
    end
    m_ready = 1'b1;
    wait_frames("stall_frames", 3);

    // three back-to-back frames, stray done during LOAD
    f0 = 3;
    clr_counters();
    repeat (3) push_frame();
    last_hs_cyc = -1;
    b2b_mode = 1'b1;
    s_valid = 1'b1;
    run = 1'b1;
    wait_frames("b2b_f1", f0 + 1);
    check("b2b_in_load", dbg_state, LOAD);
    repeat (3) step();
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    check("stray_done_state", dbg_state, LOAD);
    check("stray_done_start", fft_start, 0);
    wait_frames("b2b_f2", f0 + 2);
    run = 1'b0;
    wait_frames("b2b_f3", f0 + 3);
    check("b2b_loads", load_cnt, 3 * NP);
    step();
    check("b2b_idle", busy, 0);
    b2b_mode = 1'b0;
    s_valid = 1'b0;
    check("sb_empty", exp_q.size(), 0);

    // watchdog expiry on the TIMEOUT=16 instance
    wd_start_cnt = 0;
    run2 = 1'b1;
    s_valid2 = 1'b1;
    n = 0;
    while (!err2 && n < 200) begin
      step();
      n++;
    end
    check("wd_err", err2, 1);
    check("wd_start_cycles", wd_start_cnt, 16);
    check("wd_start_drop", fft_start2, 0);
    check("wd_busy", busy2, 0);
    check("wd_state", dbg_state2, IDLE);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (s_ready2 || busy2) seen = 1'b1;
    end
    check("wd_stuck_idle", seen, 0);
    check("wd_err_sticky", err2, 1);
    reset = 1'b1;
    run2 = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("wd_err_clr", err2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
